// File: rtl/lockin_pkg.sv
// lockin_pkg: shared state type and width helper for the lock-in MAC.
// Imported by the interface, the multiplier pipe and the top.
package lockin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Accumulator width: full product plus headroom for 2^log2n terms.
  function automatic int calc_acc_w(
    input int q1,
    input int q2,
    input int log2n
  );
    return q1 + q2 + log2n;
  endfunction

endpackage

// File: rtl/lockin_mac_iq_if.sv
// lockin_mac_iq_if: sample stream in (x, ref_i, ref_q, in_valid),
// block results out (y_i, y_q, out_valid). slave = the MAC side.
interface lockin_mac_iq_if
  import lockin_pkg::*;
#(
  parameter int Q1        = 14,
  parameter int Q2        = 16,
  parameter int LOG2_NMAX = 4
);

  localparam int ACC_W = calc_acc_w(Q1, Q2, LOG2_NMAX);

  logic [Q1-1:0]    x;
  logic [Q2-1:0]    ref_i;
  logic [Q2-1:0]    ref_q;
  logic             in_valid;
  logic [ACC_W-1:0] y_i;
  logic [ACC_W-1:0] y_q;
  logic             out_valid;

  modport master (
    output x, ref_i, ref_q, in_valid,
    input  y_i, y_q, out_valid
  );

  modport slave (
    input  x, ref_i, ref_q, in_valid,
    output y_i, y_q, out_valid
  );

endinterface

// File: rtl/lockin_mac_iq_mult_pipe.sv
// mult_pipe: 2-stage registered multiplier (operand regs, product regs).
// Ports: clk, reset_n, flush (drop stage-2 valid), in_valid/a/b, out_valid/p.
module mult_pipe #(
  parameter int Q1     = 14,
  parameter int Q2     = 16,
  parameter int SIGNED = 1,
  localparam int PW    = Q1 + Q2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [Q1-1:0] a,
  input  logic [Q2-1:0] b,
  output logic          out_valid,
  output logic [PW-1:0] p
);

  logic [Q1-1:0] a_r;
  logic [Q2-1:0] b_r;
  logic          v1;
  logic [PW-1:0] p_r;
  logic          v2;

  logic          sa;
  logic          sb;
  logic [PW-1:0] ax;
  logic [PW-1:0] bx;
  logic [PW-1:0] prod;

  // Extending both operands to PW bits makes the low PW bits of a
  // plain multiply equal to the signed (or unsigned) product.
  assign sa   = (SIGNED != 0) && a_r[Q1-1];
  assign sb   = (SIGNED != 0) && b_r[Q2-1];
  assign ax   = {{Q2{sa}}, a_r};
  assign bx   = {{Q1{sb}}, b_r};
  assign prod = ax * bx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r <= '0;
      b_r <= '0;
      v1  <= 1'b0;
      p_r <= '0;
      v2  <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_r <= a;
        b_r <= b;
      end
      v2 <= v1 && !flush;
      if (v1) begin
        p_r <= prod;
      end
    end
  end

  assign out_valid = v2;
  assign p         = p_r;

endmodule

// File: rtl/lockin_mac_iq.sv
// lockin_mac_iq: I/Q lock-in multiply-accumulate over blocks of n samples.
// Ports: clk, reset_n, start/n_acc/continuous control, busy, bus (slave).
module lockin_mac_iq
  import lockin_pkg::*;
#(
  parameter int Q1        = 14,
  parameter int Q2        = 16,
  parameter int LOG2_NMAX = 4,
  parameter int SIGNED    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LOG2_NMAX:0] n_acc,
  input  logic               continuous,
  output logic               busy,
  lockin_mac_iq_if.slave     bus
);

  localparam int ACC_W = calc_acc_w(Q1, Q2, LOG2_NMAX);
  localparam int PW    = Q1 + Q2;
  localparam int XW    = ACC_W - PW;
  localparam int CW    = LOG2_NMAX + 1;
  localparam logic [CW-1:0] NMAX =
    {1'b1, {LOG2_NMAX{1'b0}}};

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]    n_lat;
  logic             cont_lat;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc_i;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] y_i_r;
  logic [ACC_W-1:0] y_q_r;
  logic             ov_r;

  logic [PW-1:0]    p_i;
  logic [PW-1:0]    p_q;
  logic             pv_i;
  logic             pv_q;
  logic [ACC_W-1:0] ext_i;
  logic [ACC_W-1:0] ext_q;
  logic             sx_i;
  logic             sx_q;

  logic             n_nz;
  logic [CW-1:0]    n_clamp;
  logic [CW-1:0]    cnt_inc;
  logic             acc_en;
  logic             dump;
  logic             stop;
  logic             flush;
  logic             cap;

  assign n_nz    = |n_acc;
  assign n_clamp = (n_acc > NMAX) ? NMAX : n_acc;
  assign cnt_inc = cnt + CW'(1);

  assign acc_en = (state_q == ACC) && pv_i && pv_q;
  assign dump   = acc_en && (cnt_inc == n_lat);
  assign stop   = dump && !cont_lat;

  // A restart or a one-shot dump drops whatever is still in flight;
  // a start-cycle sample is kept as the first of the new block.
  assign flush = start || stop;
  assign cap   = bus.in_valid &&
                 (start ? n_nz
                        : ((state_q == ACC) && !stop));

  mult_pipe #(
    .Q1     (Q1),
    .Q2     (Q2),
    .SIGNED (SIGNED)
  ) u_mul_i (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (cap),
    .a         (bus.x),
    .b         (bus.ref_i),
    .out_valid (pv_i),
    .p         (p_i)
  );

  mult_pipe #(
    .Q1     (Q1),
    .Q2     (Q2),
    .SIGNED (SIGNED)
  ) u_mul_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (cap),
    .a         (bus.x),
    .b         (bus.ref_q),
    .out_valid (pv_q),
    .p         (p_q)
  );

  assign sx_i  = (SIGNED != 0) && p_i[PW-1];
  assign sx_q  = (SIGNED != 0) && p_q[PW-1];
  assign ext_i = {{XW{sx_i}}, p_i};
  assign ext_q = {{XW{sx_q}}, p_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = n_nz ? ACC : IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_lat    <= '0;
      cont_lat <= 1'b0;
      cnt      <= '0;
      acc_i    <= '0;
      acc_q    <= '0;
      y_i_r    <= '0;
      y_q_r    <= '0;
      ov_r     <= 1'b0;
    end else begin
      ov_r <= dump;
      if (dump) begin
        y_i_r <= acc_i + ext_i;
        y_q_r <= acc_q + ext_q;
      end
      if (start || dump) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (acc_en) begin
        acc_i <= acc_i + ext_i;
        acc_q <= acc_q + ext_q;
        cnt   <= cnt_inc;
      end
      if (start) begin
        n_lat    <= n_clamp;
        cont_lat <= continuous;
      end
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.y_i       = y_i_r;
  assign bus.y_q       = y_q_r;
  assign bus.out_valid = ov_r;

endmodule
